// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared widths, func3 codes, FSM encoding and helpers for the RV64M sequencer.
package muldiv_seq_pkg;
    localparam int XLEN = 64;
    localparam int WLEN = 32;
    localparam logic [2:0] F3_MUL = 3'b000;
    localparam logic [5:0] CNT_FULL = 6'(XLEN - 1);
    localparam logic [5:0] CNT_WORD = 6'(WLEN - 1);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    function automatic logic [XLEN-1:0] sextWord(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction
endpackage

// File: rtl/muldiv_seq_core.sv
// muldiv_seq_core: one radix-2 step, shift-add multiply or restoring divide on {hi, lo}.
module muldiv_seq_core
    import muldiv_seq_pkg::*;
(
    input  logic            isDiv,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hiNext,
    output logic [XLEN-1:0] loNext
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic          fits;
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[XLEN-1]};
        fits = shifted >= {1'b0, operand};
        // the partial remainder stays below the divisor, so the restored value fits in XLEN bits
        hiNext = isDiv ? (fits ? shifted[XLEN-1:0] - operand : shifted[XLEN-1:0]) : sum[XLEN:1];
        loNext = isDiv ? {lo[XLEN-2:0], fits} : {sum[0], lo[XLEN-1:1]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M multiply/divide sequencer with valid/ready in and out.
// Operands run as magnitudes; FIX applies sign and *W extension before DONE.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ct,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    state_t            state, stateNext;
    logic [5:0]        counter;
    logic [XLEN-1:0]   hi, lo, opnd, hiNext, loNext;
    logic [2:0]        func3, f3In;
    logic              isWordReg, negReg, negNext;
    logic              accept, signed1, signed2, neg1, neg2, divZero, divOvf, special;
    logic [XLEN-1:0]   a1, a2, m1, m2, specialRes, fixRes;
    logic [XLEN-1:0]   quot, quotAdj, remAdj, divVal;
    logic [2*XLEN-1:0] prod, prodAdj;
    logic              unusedCt;

    assign unusedCt  = alu_ct[3];
    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign out_valid = state == DONE;
    assign f3In      = alu_ct[2:0];

    always_comb begin
        accept = in_valid & in_ready & alu_ct[4] & ~flush;
        signed1 = f3In[2] ? ~f3In[0] : (f3In[1:0] != 2'b11);
        signed2 = f3In[2] ? ~f3In[0] : ~f3In[1];
        a1 = is_word ? (signed1 ? sextWord(src1[WLEN-1:0]) : {{(XLEN-WLEN){1'b0}}, src1[WLEN-1:0]}) : src1;
        a2 = is_word ? (signed2 ? sextWord(src2[WLEN-1:0]) : {{(XLEN-WLEN){1'b0}}, src2[WLEN-1:0]}) : src2;
        neg1 = signed1 & a1[XLEN-1];
        neg2 = signed2 & a2[XLEN-1];
        m1 = neg1 ? -a1 : a1;
        m2 = neg2 ? -a2 : a2;
        negNext = (f3In[2] & f3In[1]) ? neg1 : neg1 ^ neg2;
        divZero = f3In[2] & (a2 == '0);
        divOvf = f3In[2] & signed2 & (&a2) &
                 (a1 == (is_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}}));
        special = divZero | divOvf;
        specialRes = divZero ? (f3In[1] ? (is_word ? sextWord(src1[WLEN-1:0]) : src1) : '1)
                             : (f3In[1] ? '0 : a1);
        // word products sit in the top of the 2*XLEN register after only WLEN shifts
        prod = isWordReg ? {hi, lo} >> WLEN : {hi, lo};
        prodAdj = negReg ? -prod : prod;
        quot = isWordReg ? {{(XLEN-WLEN){1'b0}}, lo[WLEN-1:0]} : lo;
        quotAdj = negReg ? -quot : quot;
        remAdj = negReg ? -hi : hi;
        divVal = func3[1] ? remAdj : quotAdj;
        fixRes = func3[2] ? (isWordReg ? sextWord(divVal[WLEN-1:0]) : divVal)
               : func3 == F3_MUL ? (isWordReg ? sextWord(prodAdj[WLEN-1:0]) : prodAdj[XLEN-1:0])
               : prodAdj[2*XLEN-1:XLEN];
    end

    always_comb begin
        stateNext = state;
        if (flush) stateNext = IDLE;
        else begin
            case (state)
                IDLE:     if (accept) stateNext = special ? DONE : (f3In[2] ? DIV : MUL);
                MUL, DIV: if (counter == '0) stateNext = FIX;
                FIX:      stateNext = DONE;
                DONE:     if (out_ready) stateNext = IDLE;
                default:  stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= stateNext;
    end

    muldiv_seq_core core (
        .isDiv   (state == DIV),
        .hi      (hi),
        .lo      (lo),
        .operand (opnd),
        .hiNext  (hiNext),
        .loNext  (loNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            func3     <= '0;
            isWordReg <= 1'b0;
            negReg    <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            counter   <= is_word ? CNT_WORD : CNT_FULL;
            hi        <= '0;
            lo        <= (f3In[2] & is_word) ? {m1[WLEN-1:0], {WLEN{1'b0}}} : m1;
            opnd      <= m2;
            func3     <= f3In;
            isWordReg <= is_word;
            negReg    <= negNext;
            if (special) result <= specialRes;
        end else if (state == MUL || state == DIV) begin
            hi <= hiNext;
            lo <= loNext;
            if (counter != '0) counter <= counter - 1'b1;
        end else if (state == FIX && !flush) begin
            result <= fixRes;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    logic        clk, rst, in_valid, in_ready, is_word, flush, out_valid, out_ready, busy;
    logic [4:0]  alu_ct;
    logic [63:0] src1, src2, result;
    logic [63:0] expRes;
    logic        expActive;
    int          total, bad;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_ct(alu_ct),
        .is_word(is_word), .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        int x, y, q, r;
        logic [31:0] ux, uy, uq, ur;
        longint xl, yl, ql, rl;
        logic [63:0] uxl, uyl, uql, url;
        sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
        ua = {64'b0, a}; ub = {64'b0, b};
        if (!f3[2]) begin
            case (f3[1:0])
                2'b00, 2'b01: p = sa * sb;
                2'b10:        p = sa * ub;
                default:      p = ua * ub;
            endcase
            if (f3[1:0] == 2'b00) return w ? sx(p[31:0]) : p[63:0];
            return p[127:64];
        end
        if (w && !f3[0]) begin
            x = a[31:0]; y = b[31:0];
            if (y == 0) begin q = -1; r = x; end
            else if (x == int'(32'h8000_0000) && y == -1) begin q = x; r = 0; end
            else begin q = x / y; r = x % y; end
            return sx(f3[1] ? r : q);
        end
        if (w) begin
            ux = a[31:0]; uy = b[31:0];
            if (uy == 0) begin uq = '1; ur = ux; end
            else begin uq = ux / uy; ur = ux % uy; end
            return sx(f3[1] ? ur : uq);
        end
        if (!f3[0]) begin
            xl = a; yl = b;
            if (yl == 0) begin ql = -1; rl = xl; end
            else if (xl == longint'(64'h8000_0000_0000_0000) && yl == -1) begin ql = xl; rl = 0; end
            else begin ql = xl / yl; rl = xl % yl; end
            return f3[1] ? rl : ql;
        end
        uxl = a; uyl = b;
        if (uyl == 0) begin uql = '1; url = uxl; end
        else begin uql = uxl / uyl; url = uxl % uyl; end
        return f3[1] ? url : uql;
    endfunction

    function automatic logic isSpecial(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        if (!f3[2]) return 1'b0;
        if (w ? (b[31:0] == 0) : (b == 0)) return 1'b1;
        if (f3[0]) return 1'b0;
        return w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                 : (a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // every cycle a result is presented it must be one the model is waiting for
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("cmp_expected", 64'(expActive), 64'd1);
            chk("cmp_result", result, expRes);
        end
    end

    task automatic startOp(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_valid = 1'b1; alu_ct = {1'b1, f3[0], f3}; is_word = w; src1 = a; src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    endtask

    task automatic doOp(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input int hold, output logic [63:0] got);
        int expLat, lat;
        // a special divide shows out_valid already in the cycle right after the accept edge
        expLat = isSpecial(f3, w, a, b) ? 0 : (w ? 33 : 65);
        expRes = model(f3, w, a, b);
        expActive = 1'b1;
        chk("idle_ready", 64'(in_ready), 64'd1);
        startOp(f3, w, a, b);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(expLat));
        got = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", result, got);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; expActive = 1'b0;
        chk("released", 64'(out_valid), 64'd0);
        chk("ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] got, prevRes, a, b;
        logic [2:0] f3;
        logic w, sawValid;
        total = 0; bad = 0;
        rst = 1'b1; in_valid = 1'b0; alu_ct = '0; is_word = 1'b0; src1 = '0; src2 = '0;
        flush = 1'b0; out_ready = 1'b0; expActive = 1'b0; expRes = '0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        doOp(3'b000, 1'b0, 64'd7, -64'd3, 0, got);
        chk("lit_mul", got, 64'hFFFF_FFFF_FFFF_FFEB);
        doOp(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, got);
        chk("lit_mulhu", got, 64'd1);
        doOp(3'b001, 1'b0, '1, '1, 0, got);
        chk("lit_mulh", got, 64'd0);
        doOp(3'b100, 1'b0, -64'd7, 64'd2, 0, got);
        chk("lit_div", got, -64'd3);
        doOp(3'b110, 1'b0, -64'd7, 64'd2, 0, got);
        chk("lit_rem", got, '1);
        doOp(3'b101, 1'b0, 64'd5, 64'd0, 0, got);
        chk("lit_divu0", got, 64'hFFFF_FFFF_FFFF_FFFF);
        doOp(3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 0, got);
        chk("lit_divw_ovf", got, 64'hFFFF_FFFF_8000_0000);
        doOp(3'b110, 1'b1, 64'h0000_0000_8000_0000, '1, 0, got);
        chk("lit_remw_ovf", got, 64'd0);
        doOp(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 0, got);
        chk("lit_mulw", got, 64'hFFFF_FFFF_FFFF_FFFE);
        doOp(3'b101, 1'b0, 64'd100, 64'd7, 5, got);
        chk("lit_divu_hold", got, 64'd14);
        prevRes = got;

        @(negedge clk);
        in_valid = 1'b1; alu_ct = 5'b00100; src1 = 64'd9; src2 = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ignored_busy", 64'(busy), 64'd0);

        @(negedge clk);
        in_valid = 1'b1; alu_ct = 5'b10000; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", 64'(busy), 64'd0);

        startOp(3'b000, 1'b0, 64'd123, 64'd456);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        sawValid = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1'b1;
        end
        chk("flush_no_output", 64'(sawValid), 64'd0);
        chk("flush_result_held", result, prevRes);

        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            w = (f3 == 3'b000 || f3[2]) && $urandom_range(0, 2) == 0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = w ? {b[63:32], 32'd0} : 64'd0;
                1: begin
                    a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
                end
                2: begin
                    a = $urandom_range(0, 1) ? 64'($urandom_range(0, 100)) : -64'($urandom_range(0, 100));
                    b = $urandom_range(0, 1) ? 64'($urandom_range(1, 20)) : -64'($urandom_range(1, 20));
                end
                default: ;
            endcase
            doOp(f3, w, a, b, $urandom_range(0, 3), got);
        end

        startOp(3'b100, 1'b0, 64'd1000, 64'd7);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_result", result, 64'd0);
        @(negedge clk); rst = 1'b0;
        doOp(3'b100, 1'b0, 64'd1000, 64'd7, 0, got);
        chk("lit_after_rst", got, 64'd142);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
